// File: rtl/marker_recorder_fifo_if.sv
// rtl/marker_recorder_fifo_if.sv - move request / board status bundle for marker_recorder_fifo
interface marker_recorder_fifo_if #(
  parameter int CELLS = 9,
  parameter int DEPTH = 3,
  parameter int POS_W = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             enable;
  logic             clear;
  logic             move_valid;
  logic             move_player;
  logic [POS_W-1:0] pos;
  logic             move_ack;
  logic             move_err;
  logic [1:0]       err_code;
  logic [CELLS-1:0] grid_a;
  logic [CELLS-1:0] grid_b;
  logic [CNT_W-1:0] count_a;
  logic [CNT_W-1:0] count_b;
  logic             turn;
  logic [POS_W-1:0] oldest_a;
  logic [POS_W-1:0] oldest_b;
  logic             oldest_vld_a;
  logic             oldest_vld_b;

  // Game controller side: issues moves, observes the board.
  modport master (
    output enable, clear, move_valid, move_player, pos,
    input  move_ack, move_err, err_code, grid_a, grid_b, count_a, count_b,
    input  turn, oldest_a, oldest_b, oldest_vld_a, oldest_vld_b
  );

  // Recorder side.
  modport slave (
    input  enable, clear, move_valid, move_player, pos,
    output move_ack, move_err, err_code, grid_a, grid_b, count_a, count_b,
    output turn, oldest_a, oldest_b, oldest_vld_a, oldest_vld_b
  );
endinterface

// File: rtl/marker_recorder_fifo.sv
// rtl/marker_recorder_fifo.sv - two-player board where each player keeps at most DEPTH live marks
// Each player owns a circular FIFO of mark positions; a move by a player
// holding DEPTH marks retires that player's oldest mark on the same edge.
module marker_recorder_fifo #(
  parameter int CELLS = 9,
  parameter int DEPTH = 3,
  parameter int POS_W = 4
) (
  input logic                  clk,
  input logic                  reset,
  marker_recorder_fifo_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Index 0 = player A (circle), index 1 = player B (cross).
  logic [POS_W-1:0] r_fifo  [2][DEPTH];
  logic [PTR_W-1:0] r_head  [2];
  logic [PTR_W-1:0] r_tail  [2];
  logic [CNT_W-1:0] r_count [2];
  logic [CELLS-1:0] r_grid  [2];
  logic             r_turn;
  logic             r_ack;
  logic             r_err;
  logic [1:0]       r_code;

  logic             w_sample;
  logic             w_pl;
  logic [1:0]       w_code;
  logic             w_full;
  logic [CELLS-1:0] w_occ_all;
  logic [CELLS-1:0] w_set_mask;
  logic [CELLS-1:0] w_pop_mask;

  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // Judge the incoming request against the pre-edge board, in priority order.
  always_comb begin
    w_sample   = bus.enable & ~bus.clear & bus.move_valid;
    w_pl       = bus.move_player;
    w_occ_all  = r_grid[0] | r_grid[1];
    w_code     = 2'b00;
    if (32'(bus.pos) >= CELLS)
      w_code = 2'b10;
    else if (w_pl != r_turn)
      w_code = 2'b11;
    else if (w_occ_all[bus.pos])
      w_code = 2'b01;
    w_full     = (32'(r_count[w_pl]) == DEPTH);
    w_set_mask = CELLS'(1) << bus.pos;
    w_pop_mask = w_full ? (CELLS'(1) << r_fifo[w_pl][r_head[w_pl]]) : '0;
  end

  // Board state, FIFOs and one-cycle result pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        r_head[i]  <= '0;
        r_tail[i]  <= '0;
        r_count[i] <= '0;
        r_grid[i]  <= '0;
        for (int j = 0; j < DEPTH; j++) r_fifo[i][j] <= '0;
      end
      r_turn <= 1'b0;
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_code <= 2'b00;
    end else begin
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_code <= 2'b00;
      if (bus.clear) begin
        for (int i = 0; i < 2; i++) begin
          r_head[i]  <= '0;
          r_tail[i]  <= '0;
          r_count[i] <= '0;
          r_grid[i]  <= '0;
          for (int j = 0; j < DEPTH; j++) r_fifo[i][j] <= '0;
        end
        r_turn <= 1'b0;
      end else if (w_sample) begin
        if (w_code != 2'b00) begin
          r_err  <= 1'b1;
          r_code <= w_code;
        end else begin
          // The set cell is known free, so it never collides with the popped one.
          r_grid[w_pl]              <= (r_grid[w_pl] & ~w_pop_mask) | w_set_mask;
          r_fifo[w_pl][r_tail[w_pl]] <= bus.pos;
          r_tail[w_pl]              <= f_inc(r_tail[w_pl]);
          if (w_full)
            r_head[w_pl] <= f_inc(r_head[w_pl]);
          else
            r_count[w_pl] <= r_count[w_pl] + 1'b1;
          r_turn <= ~r_turn;
          r_ack  <= 1'b1;
        end
      end
    end
  end

  assign bus.move_ack     = r_ack;
  assign bus.move_err     = r_err;
  assign bus.err_code     = r_code;
  assign bus.grid_a       = r_grid[0];
  assign bus.grid_b       = r_grid[1];
  assign bus.count_a      = r_count[0];
  assign bus.count_b      = r_count[1];
  assign bus.turn         = r_turn;
  assign bus.oldest_a     = r_fifo[0][r_head[0]];
  assign bus.oldest_b     = r_fifo[1][r_head[1]];
  assign bus.oldest_vld_a = (32'(r_count[0]) == DEPTH);
  assign bus.oldest_vld_b = (32'(r_count[1]) == DEPTH);
endmodule
